// File: rtl/mmwave_cfg_pkg.sv
// mmwave_cfg_pkg
// Shared definitions for the mmWave configuration shadow register file:
// commit FSM encoding, register index map and field bit offsets inside the
// system, VCO, ADC and UDP registers.
package mmwave_cfg_pkg;

    // Commit FSM: IDLE collects writes, ARMED waits for the apply trigger.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cfg_state_e;

    // Register index map.
    localparam int unsigned SYS      = 0;
    localparam int unsigned VCO      = 1;
    localparam int unsigned AD       = 2;
    localparam int unsigned UDP_IP   = 3;
    localparam int unsigned UDP_PORT = 4;
    localparam int unsigned DSP      = 5;

    // System register fields.
    localparam int unsigned SYS_RUN_BIT        = 0;
    localparam int unsigned SYS_MODE_LSB       = 1;
    localparam int unsigned SYS_MODE_W         = 3;
    localparam int unsigned SYS_TX_EN_LSB      = 4;
    localparam int unsigned SYS_TX_EN_W        = 4;

    // VCO / chirp register fields.
    localparam int unsigned VCO_START_FREQ_LSB = 0;
    localparam int unsigned VCO_START_FREQ_W   = 32;
    localparam int unsigned VCO_SLOPE_LSB      = 32;
    localparam int unsigned VCO_SLOPE_W        = 16;
    localparam int unsigned VCO_IDLE_TIME_LSB  = 48;
    localparam int unsigned VCO_IDLE_TIME_W    = 16;

    // ADC sampling register fields.
    localparam int unsigned AD_SAMPLE_RATE_LSB = 0;
    localparam int unsigned AD_SAMPLE_RATE_W   = 16;
    localparam int unsigned AD_NUM_SAMPLES_LSB = 16;
    localparam int unsigned AD_NUM_SAMPLES_W   = 16;

    // UDP destination fields.
    localparam int unsigned UDP_IP_ADDR_LSB    = 0;
    localparam int unsigned UDP_IP_ADDR_W      = 32;
    localparam int unsigned UDP_PORT_NUM_LSB   = 0;
    localparam int unsigned UDP_PORT_NUM_W     = 16;

endpackage

// File: rtl/mmwave_cfg_bank.sv
// mmwave_cfg_bank
// Shadow register storage with per-register dirty mask. Decodes writes,
// drops writes whose index is beyond REG_NUM and flags them with a one-cycle
// error pulse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en_i      write strobe
//   wr_index_i   target register
//   wr_data_i    write data
//   clr_mask_i   dirty bits to clear (registers being applied this cycle)
//   shadow_o     shadow bank contents
//   dirty_o      written-since-last-apply mask
//   wr_err_o     one-cycle pulse after a dropped write
module mmwave_cfg_bank
    import mmwave_cfg_pkg::*;
#(
    parameter int unsigned REG_NUM     = 8,
    parameter int unsigned REG_WIDTH   = 64,
    parameter int unsigned IDX_W       = $clog2(REG_NUM),
    parameter logic [REG_NUM*REG_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en_i,
    input  logic [IDX_W-1:0]                    wr_index_i,
    input  logic [REG_WIDTH-1:0]                wr_data_i,
    input  logic [REG_NUM-1:0]                  clr_mask_i,
    output logic [REG_NUM-1:0][REG_WIDTH-1:0]   shadow_o,
    output logic [REG_NUM-1:0]                  dirty_o,
    output logic                                wr_err_o
);

    localparam logic [IDX_W:0] REG_NUM_L = (IDX_W+1)'(REG_NUM);

    logic [REG_NUM-1:0][REG_WIDTH-1:0] shadow_q, shadow_d;
    logic [REG_NUM-1:0]                dirty_q, dirty_d;
    logic                              wr_err_q, wr_err_d;
    logic                              wr_ok_s;

    // Write decode: the clear is applied first so a write landing in the
    // apply cycle keeps its register dirty.
    always_comb begin
        wr_ok_s  = wr_en_i && ({1'b0, wr_index_i} < REG_NUM_L);
        shadow_d = shadow_q;
        dirty_d  = dirty_q & ~clr_mask_i;
        wr_err_d = wr_en_i && !wr_ok_s;
        if (wr_ok_s) begin
            shadow_d[wr_index_i] = wr_data_i;
            dirty_d[wr_index_i]  = 1'b1;
        end else begin
            shadow_d = shadow_d;
        end
    end

    // Shadow, dirty and error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RESET_VALUE;
            dirty_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign shadow_o = shadow_q;
    assign dirty_o  = dirty_q;
    assign wr_err_o = wr_err_q;

endmodule

// File: rtl/mmwave_cfg_shadow_regfile.sv
// mmwave_cfg_shadow_regfile
// Double-buffered configuration register file. Writes land in the shadow
// bank; a commit copies the dirty registers into the active bank either at
// the next frame_sync_i pulse or immediately, so live parameters never change
// mid-frame.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_wr_*_i                 register write (one per cycle, never stalls)
//   cfg_commit_req_i           commit request pulse
//   cfg_commit_immediate_i     1 = apply without waiting for frame_sync_i
//   cfg_commit_abort_i         cancel an armed commit
//   frame_sync_i               frame-boundary pulse
//   rd_en_i/rd_index_i/rd_shadow_i  readback request (shadow or active bank)
//   rd_data_o/rd_valid_o       readback result, one cycle later
//   cfg_active_o               active bank, flattened
//   cfg_dirty_o                registers written since their last apply
//   cfg_pending_o              commit armed
//   cfg_update_o               one-cycle pulse when the active bank changes
//   cfg_update_mask_o          registers applied by the last commit
//   cfg_wr_err_o               one-cycle pulse on a dropped write
//   cfg_commit_cnt_o           applied-commit counter (wraps)
module mmwave_cfg_shadow_regfile
    import mmwave_cfg_pkg::*;
#(
    parameter int unsigned REG_NUM     = 8,
    parameter int unsigned REG_WIDTH   = 64,
    parameter int unsigned IDX_W       = $clog2(REG_NUM),
    parameter logic [REG_NUM*REG_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_wr_en_i,
    input  logic [IDX_W-1:0]             cfg_wr_index_i,
    input  logic [REG_WIDTH-1:0]         cfg_wr_data_i,
    input  logic                         cfg_commit_req_i,
    input  logic                         cfg_commit_immediate_i,
    input  logic                         cfg_commit_abort_i,
    input  logic                         frame_sync_i,
    input  logic                         rd_en_i,
    input  logic [IDX_W-1:0]             rd_index_i,
    input  logic                         rd_shadow_i,
    output logic [REG_WIDTH-1:0]         rd_data_o,
    output logic                         rd_valid_o,
    output logic [REG_NUM*REG_WIDTH-1:0] cfg_active_o,
    output logic [REG_NUM-1:0]           cfg_dirty_o,
    output logic                         cfg_pending_o,
    output logic                         cfg_update_o,
    output logic [REG_NUM-1:0]           cfg_update_mask_o,
    output logic                         cfg_wr_err_o,
    output logic [7:0]                   cfg_commit_cnt_o
);

    localparam logic [IDX_W:0] REG_NUM_L = (IDX_W+1)'(REG_NUM);

    logic [REG_NUM-1:0][REG_WIDTH-1:0] shadow_s;
    logic [REG_NUM-1:0]                dirty_s;
    logic [REG_NUM-1:0]                clr_mask_s;
    logic                              wr_err_s;
    logic                              apply_s;
    logic                              rd_ok_s;

    cfg_state_e                        state_q, state_d;
    logic                              imm_q, imm_d;
    logic [REG_NUM-1:0][REG_WIDTH-1:0] active_q, active_d;
    logic                              update_q, update_d;
    logic [REG_NUM-1:0]                update_mask_q, update_mask_d;
    logic [7:0]                        commit_cnt_q, commit_cnt_d;
    logic [REG_WIDTH-1:0]              rd_data_q, rd_data_d;
    logic                              rd_valid_q, rd_valid_d;

    mmwave_cfg_bank #(
        .REG_NUM     (REG_NUM),
        .REG_WIDTH   (REG_WIDTH),
        .IDX_W       (IDX_W),
        .RESET_VALUE (RESET_VALUE)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (cfg_wr_en_i),
        .wr_index_i (cfg_wr_index_i),
        .wr_data_i  (cfg_wr_data_i),
        .clr_mask_i (clr_mask_s),
        .shadow_o   (shadow_s),
        .dirty_o    (dirty_s),
        .wr_err_o   (wr_err_s)
    );

    // Commit FSM next-state; abort has priority over an apply trigger.
    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        apply_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_commit_req_i && (dirty_s != '0)) begin
                    state_d = ARMED;
                    imm_d   = cfg_commit_immediate_i;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (cfg_commit_abort_i) begin
                    state_d = IDLE;
                end else if (imm_q || frame_sync_i) begin
                    state_d = IDLE;
                    apply_s = 1'b1;
                end else begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Apply datapath: copy dirty shadow entries into the active bank.
    always_comb begin
        active_d      = active_q;
        clr_mask_s    = '0;
        update_d      = apply_s;
        update_mask_d = update_mask_q;
        commit_cnt_d  = commit_cnt_q;
        if (apply_s) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                if (dirty_s[i]) begin
                    active_d[i] = shadow_s[i];
                end else begin
                    active_d[i] = active_q[i];
                end
            end
            clr_mask_s    = dirty_s;
            update_mask_d = dirty_s;
            commit_cnt_d  = commit_cnt_q + 8'd1;
        end else begin
            commit_cnt_d  = commit_cnt_q;
        end
    end

    // Readback mux; sees bank contents from before this edge.
    always_comb begin
        rd_ok_s    = {1'b0, rd_index_i} < REG_NUM_L;
        rd_valid_d = rd_en_i;
        rd_data_d  = '0;
        if (rd_en_i && rd_ok_s) begin
            if (rd_shadow_i) begin
                rd_data_d = shadow_s[rd_index_i];
            end else begin
                rd_data_d = active_q[rd_index_i];
            end
        end else begin
            rd_data_d = '0;
        end
    end

    // FSM, active bank, status and readback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            imm_q         <= 1'b0;
            active_q      <= RESET_VALUE;
            update_q      <= 1'b0;
            update_mask_q <= '0;
            commit_cnt_q  <= 8'd0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            imm_q         <= imm_d;
            active_q      <= active_d;
            update_q      <= update_d;
            update_mask_q <= update_mask_d;
            commit_cnt_q  <= commit_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rd_data_o         = rd_data_q;
    assign rd_valid_o        = rd_valid_q;
    assign cfg_active_o      = active_q;
    assign cfg_dirty_o       = dirty_s;
    assign cfg_pending_o     = (state_q == ARMED);
    assign cfg_update_o      = update_q;
    assign cfg_update_mask_o = update_mask_q;
    assign cfg_wr_err_o      = wr_err_s;
    assign cfg_commit_cnt_o  = commit_cnt_q;

endmodule

// File: doc/mmwave_cfg_shadow_regfile.md
# mmwave_cfg_shadow_regfile

Parametrised, double-buffered configuration register file for the mmWave front end. UART-decoded register writes land in a shadow bank and are applied atomically to the active bank only on a commit, either at the next frame boundary or immediately. The active bank feeds the chirp/VCO, ADC-sampling, UDP and DSP control fields, so live parameters never change mid-frame. Replaces the fixed 8-entry, 64-bit register file behind the UART config path.

## Interface
- REG_NUM, 8: number of registers (2..32).
- REG_WIDTH, 64: bits per register (8..64).
- IDX_W, $clog2(REG_NUM): index width (derived, not overridden).
- RESET_VALUE, all zeros: REG_NUM*REG_WIDTH reset image; register i in bits [i*REG_WIDTH +: REG_WIDTH].
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_wr_en_i  in  1  write strobe, one write per cycle.
- cfg_wr_index_i  in  IDX_W  target register.
- cfg_wr_data_i  in  REG_WIDTH  write data.
- cfg_commit_req_i  in  1  commit request pulse.
- cfg_commit_immediate_i  in  1  sampled with commit_req: 1 = apply without waiting for frame sync.
- cfg_commit_abort_i  in  1  cancel a pending commit.
- frame_sync_i  in  1  one-cycle frame-boundary pulse from the chirp timer.
- rd_en_i  in  1  readback request.
- rd_index_i  in  IDX_W  readback register.
- rd_shadow_i  in  1  1 = read shadow bank, 0 = read active bank.
- rd_data_o  out  REG_WIDTH  readback data.
- rd_valid_o  out  1  rd_data_o valid.
- cfg_active_o  out  REG_NUM*REG_WIDTH  active bank, flattened.
- cfg_dirty_o  out  REG_NUM  shadow differs-by-write mask.
- cfg_pending_o  out  1  commit armed, waiting.
- cfg_update_o  out  1  one-cycle pulse when the active bank changes.
- cfg_update_mask_o  out  REG_NUM  registers applied by the last commit.
- cfg_wr_err_o  out  1  one-cycle pulse on dropped write.
- cfg_commit_cnt_o  out  8  applied-commit counter.

## Operation
- Reset: shadow = active = RESET_VALUE. dirty, pending, update, update_mask, wr_err, rd_valid, commit_cnt = 0. rd_data_o = 0. FSM = IDLE.
- Write: with index < REG_NUM, shadow[index] <= data and dirty[index] <= 1. With index >= REG_NUM (non-power-of-two REG_NUM), the write is dropped and cfg_wr_err_o pulses the next cycle. Writes are accepted in every state and never stall.
- FSM IDLE: on commit_req with dirty != 0, go to ARMED and latch the immediate bit. A commit_req with dirty == 0 is ignored: no pulse, no count.
- FSM ARMED: cfg_pending_o = 1. Apply fires when the latched immediate bit is 1, or when frame_sync_i = 1.
- On apply: every dirty register copies shadow to active; update_mask <= dirty; the copied dirty bits clear; commit_cnt increments (wraps 255 -> 0); return to IDLE.
- Abort in ARMED returns to IDLE with dirty and shadow kept. If abort and an apply trigger arrive in the same cycle, abort wins.
- Write to index k in the apply cycle: the active bank gets the pre-write shadow value, the shadow takes the new data, and dirty[k] stays 1.
- commit_req while ARMED: ignored. It does not change the latched immediate bit.
- Reset asserted mid-operation: everything returns to reset values, and any pending commit is lost.

## Timing
- Write at edge N: shadow and dirty are visible from N+1.
- commit_req at N: pending from N+1. An immediate commit applies at edge N+1, so active data, cfg_update_o and the mask are visible from N+2.
- frame_sync_i high in cycle M while ARMED: active data and cfg_update_o are visible from M+1. A frame_sync in the same cycle as the commit_req is not used.
- cfg_update_o is high exactly one cycle. update_mask holds until the next apply.
- Readback: rd_en_i at N gives rd_data_o and rd_valid_o (one cycle) at N+1. The read reflects bank contents before edge N. An out-of-range read returns 0 with rd_valid_o = 1.

## Structure
- Package mmwave_cfg_pkg:
  - FSM state encoding (IDLE, ARMED).
  - Register index constants: SYS=0, VCO=1, AD=2, UDP_IP=3, UDP_PORT=4, DSP=5.
  - Field bit offsets for system, VCO, ADC and UDP fields.
- Sub-module mmwave_cfg_bank: shadow storage plus dirty mask, write decode and range check. The top level holds the FSM, the active bank, readback and counters.

## Test plan
- Reset, then read active reg 1 with RESET_VALUE reg 1 = 64'h5 -> rd_data_o = 64'h5 at N+1; cfg_active_o equals RESET_VALUE.
- Write reg 2 = 64'hA5A5, commit (immediate=0), frame_sync 10 cycles later -> active reg 2 = 64'hA5A5 one cycle after frame_sync; cfg_update_o pulses once; update_mask = 8'b0000_0100; commit_cnt = 1.
- Write reg 0 = 1, immediate commit at N -> active reg 0 = 1 and cfg_update_o high at N+2; dirty = 0; pending low.
- Write reg 3 = 7 in the same cycle as the frame_sync apply -> active reg 3 keeps its old value, shadow = 7, dirty[3] stays 1; a second commit with frame_sync applies 7.
- REG_NUM=6: write index 7 -> wr_err pulses, dirty unchanged. commit_req with dirty = 0 -> no pending, count unchanged.
- Abort and frame_sync in the same cycle -> no update, dirty kept. rst_n low while ARMED -> pending = 0 and active = RESET_VALUE.
